// File: rtl/servo_sequencer.sv
// servo_sequencer: four-channel servo PWM generator with per-frame slew limiting of pulse widths.
// Ports: clk, rst (async active-high); cmd_valid/cmd_ready/cmd_ch/cmd_width set a channel target;
//        pwm_out[3:0] servo pulses; frame_start one-cycle frame marker; busy while any channel slews.
module servo_sequencer #(
  parameter int FRAME_TICKS  = 240000,
  parameter int MIN_WIDTH    = 6000,
  parameter int MAX_WIDTH    = 28800,
  parameter int CENTER_WIDTH = 17400,
  parameter int STEP         = 1200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_ch,
  input  logic [15:0] cmd_width,
  output logic [3:0]  pwm_out,
  output logic        frame_start,
  output logic        busy
);

  localparam int CW = $clog2(FRAME_TICKS);
  // Common width for comparing the frame counter against a 16-bit pulse width.
  localparam int XW = (CW > 16) ? CW : 16;

  localparam logic [CW-1:0]      LAST_CNT = CW'(FRAME_TICKS - 1);
  localparam logic [CW-1:0]      UPD_CNT  = CW'(FRAME_TICKS - 5);
  localparam logic [15:0]        MIN_W    = 16'(MIN_WIDTH);
  localparam logic [15:0]        MAX_W    = 16'(MAX_WIDTH);
  localparam logic [15:0]        CENTER_W = 16'(CENTER_WIDTH);
  localparam logic [15:0]        STEP_W   = 16'(STEP);
  localparam logic signed [16:0] STEP_S   = 17'(STEP);

  typedef enum logic [1:0] {IDLE, RUN, UPDATE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      frame_cnt;
  logic [1:0]         ch_idx;
  logic [15:0]        cur    [4];
  logic [15:0]        target [4];
  logic [15:0]        cmd_clamped;
  logic [15:0]        cur_sel, tgt_sel, cur_step;
  logic signed [16:0] delta;
  logic               cmd_fire;

  assign cmd_ready = (state == RUN);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Next-state logic. UPDATE is entered so that its four channel steps land on
  // the last four counts of the frame, returning to RUN exactly as the counter wraps.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (frame_cnt == UPD_CNT) state_nxt = UPDATE;
      UPDATE:  if (ch_idx == 2'd3) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Command width clamp into the legal servo range.
  always_comb begin
    cmd_clamped = cmd_width;
    if (cmd_width < MIN_W)      cmd_clamped = MIN_W;
    else if (cmd_width > MAX_W) cmd_clamped = MAX_W;
  end

  // Slew step for the channel under update; 17-bit signed difference cannot wrap.
  always_comb begin
    cur_sel  = cur[ch_idx];
    tgt_sel  = target[ch_idx];
    delta    = $signed({1'b0, tgt_sel}) - $signed({1'b0, cur_sel});
    cur_step = tgt_sel;
    if (delta > STEP_S)       cur_step = cur_sel + STEP_W;
    else if (delta < -STEP_S) cur_step = cur_sel - STEP_W;
  end

  // Frame counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      pwm_out     <= '0;
    end else begin
      frame_cnt   <= (frame_cnt == LAST_CNT) ? '0 : frame_cnt + CW'(1);
      frame_start <= (frame_cnt == '0);
      for (int i = 0; i < 4; i++) begin
        pwm_out[i] <= (XW'(frame_cnt) < XW'(cur[i]));
      end
    end
  end

  // Channel state: targets move only in RUN, current widths only in UPDATE,
  // and widths change only while every pulse is already low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_idx <= '0;
      for (int i = 0; i < 4; i++) begin
        cur[i]    <= CENTER_W;
        target[i] <= CENTER_W;
      end
    end else begin
      if (state == UPDATE) begin
        cur[ch_idx] <= cur_step;
        ch_idx      <= ch_idx + 2'd1;
      end else begin
        ch_idx <= 2'd0;
      end
      if (cmd_fire) target[cmd_ch] <= cmd_clamped;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cur[i] != target[i]) busy = 1'b1;
    end
  end

endmodule
